// File: rtl/sbqm_gen2.sv
// Queue manager: debounced entry/exit edges drive an occupancy FSM, and a wait-time estimate is derived from occupancy and teller count.
// Optional macro SBQM_REJECT_CNT_EN adds an 8-bit saturating count of entries rejected while the queue is full.
module sbqm_gen2 #(
  parameter int CAPACITY     = 7,
  parameter int TC_W         = 2,
  parameter int SERVICE_TIME = 3,
  localparam int PC_W        = $clog2(CAPACITY + 1),
  localparam int WT_W        = $clog2(SERVICE_TIME * CAPACITY + 1)
) (
  input  logic              clk,
  input  logic              RESET,
  input  logic              sensor_start,
  input  logic              sensor_end,
  input  logic [TC_W-1:0]   Tellers_count,
  output logic [PC_W-1:0]   People_count,
  output logic              Full_flag,
  output logic              Empty_flag,
  output logic [WT_W-1:0]   WaitTime,
  output logic              Error_flag
`ifdef SBQM_REJECT_CNT_EN
  ,
  output logic [7:0]        Reject_count
`endif
);

  localparam int MW     = PC_W + TC_W + 6;
  localparam int WT_MAX = SERVICE_TIME * CAPACITY;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    PARTIAL = 2'd1,
    FULL    = 2'd2
  } state_t;

  logic              start_hist_p0;
  logic              end_hist_p0;
  logic              armed_p0;
  logic              entry_vld_p0;
  logic              exit_vld_p0;

  logic [PC_W-1:0]   count_p1;
  state_t            state_p1;
  logic              full_p1;
  logic              empty_p1;
  logic              err_p1;

  logic [WT_W-1:0]   wait_p2;

  logic [PC_W-1:0]   count_nxt;
  logic              err_set;
  logic              reject;
  logic [TC_W-1:0]   tellers_eff;

  function automatic state_t state_of(input logic [PC_W-1:0] cnt);
    if (cnt == '0)
      return EMPTY;
    else if (cnt == PC_W'(CAPACITY))
      return FULL;
    else
      return PARTIAL;
  endfunction

  function automatic logic [WT_W-1:0] sat_wait(input logic [MW-1:0] q);
    if (q > MW'(WT_MAX))
      return WT_W'(WT_MAX);
    else
      return WT_W'(q);
  endfunction

  // floor(SERVICE_TIME*(pc+t-1)/t) is a ceiling-style round of the per-teller backlog
  function automatic logic [WT_W-1:0] wait_calc(input logic [PC_W-1:0] pc,
                                                input logic [TC_W-1:0] t);
    logic [MW-1:0] num;
    logic [MW-1:0] prod;
    logic [MW-1:0] quot;
    num  = MW'(pc) + MW'(t) - MW'(1);
    prod = MW'(SERVICE_TIME) * num;
    quot = prod / MW'(t);
    return sat_wait(quot);
  endfunction

  // The first cycle after reset only loads history, so a sensor held across release is not an edge
  assign entry_vld_p0 = armed_p0 & sensor_start & ~start_hist_p0;
  assign exit_vld_p0  = armed_p0 & sensor_end   & ~end_hist_p0;
  assign tellers_eff  = (Tellers_count == '0) ? TC_W'(1) : Tellers_count;

  always_comb begin
    count_nxt = count_p1;
    err_set   = 1'b0;
    reject    = 1'b0;
    if (entry_vld_p0 && !exit_vld_p0) begin
      if (state_p1 == FULL) begin
        err_set = 1'b1;
        reject  = 1'b1;
      end else begin
        count_nxt = count_p1 + PC_W'(1);
      end
    end else if (exit_vld_p0 && !entry_vld_p0) begin
      if (state_p1 == EMPTY)
        err_set = 1'b1;
      else
        count_nxt = count_p1 - PC_W'(1);
    end else if (entry_vld_p0 && exit_vld_p0 && state_p1 == EMPTY) begin
      count_nxt = PC_W'(1);
      err_set   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!RESET) begin
      start_hist_p0 <= 1'b0;
      end_hist_p0   <= 1'b0;
      armed_p0      <= 1'b0;
      count_p1      <= '0;
      state_p1      <= EMPTY;
      full_p1       <= 1'b0;
      empty_p1      <= 1'b1;
      err_p1        <= 1'b0;
      wait_p2       <= '0;
    end else begin
      // p0: sensor history
      start_hist_p0 <= sensor_start;
      end_hist_p0   <= sensor_end;
      armed_p0      <= 1'b1;
      // p1: occupancy, state and flags
      count_p1      <= count_nxt;
      state_p1      <= state_of(count_nxt);
      full_p1       <= (state_of(count_nxt) == FULL);
      empty_p1      <= (state_of(count_nxt) == EMPTY);
      if (err_set)
        err_p1 <= 1'b1;
      // p2: wait estimate from registered occupancy
      wait_p2       <= (count_p1 == '0) ? '0 : wait_calc(count_p1, tellers_eff);
    end
  end

`ifdef SBQM_REJECT_CNT_EN
  logic [7:0] reject_cnt_p1;

  always_ff @(posedge clk) begin
    if (!RESET)
      reject_cnt_p1 <= 8'd0;
    else if (reject && reject_cnt_p1 != 8'hFF)
      reject_cnt_p1 <= reject_cnt_p1 + 8'd1;
  end

  assign Reject_count = reject_cnt_p1;
`else
  logic unused_reject;
  assign unused_reject = reject;
`endif

  assign People_count = count_p1;
  assign Full_flag    = full_p1;
  assign Empty_flag   = empty_p1;
  assign Error_flag   = err_p1;
  assign WaitTime     = wait_p2;

endmodule

// File: tb/tb_sbqm_gen2.sv
// Directed bench for sbqm_gen2 at default parameters (CAPACITY=7, SERVICE_TIME=3, TC_W=2).
module tb_sbqm_gen2;

  logic       clk;
  logic       RESET;
  logic       sensor_start;
  logic       sensor_end;
  logic [1:0] Tellers_count;
  logic [2:0] People_count;
  logic       Full_flag;
  logic       Empty_flag;
  logic [4:0] WaitTime;
  logic       Error_flag;
`ifdef SBQM_REJECT_CNT_EN
  logic [7:0] Reject_count;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  sbqm_gen2 dut (
    .clk           (clk),
    .RESET         (RESET),
    .sensor_start  (sensor_start),
    .sensor_end    (sensor_end),
    .Tellers_count (Tellers_count),
    .People_count  (People_count),
    .Full_flag     (Full_flag),
    .Empty_flag    (Empty_flag),
    .WaitTime      (WaitTime),
    .Error_flag    (Error_flag)
`ifdef SBQM_REJECT_CNT_EN
    ,
    .Reject_count  (Reject_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Inputs change just after a falling edge; outputs are read on falling edges.
  task automatic pulse(input logic s, input logic e);
    sensor_start = s;
    sensor_end   = e;
    @(negedge clk);
    sensor_start = 1'b0;
    sensor_end   = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    RESET        = 1'b0;
    sensor_start = 1'b0;
    sensor_end   = 1'b0;
    @(negedge clk);
    @(negedge clk);
    RESET = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    RESET         = 1'b0;
    sensor_start  = 1'b0;
    sensor_end    = 1'b0;
    Tellers_count = 2'd2;
    @(negedge clk);
    @(negedge clk);

    check("rst_count", People_count, 0);
    check("rst_empty", Empty_flag, 1);
    check("rst_full", Full_flag, 0);
    check("rst_wait", WaitTime, 0);
    check("rst_err", Error_flag, 0);
    RESET = 1'b1;
    @(negedge clk);

    // First entry: count lands one edge before the wait estimate
    sensor_start = 1'b1;
    @(negedge clk);
    check("lat_count", People_count, 1);
    check("lat_wait_old", WaitTime, 0);
    sensor_start = 1'b0;
    @(negedge clk);
    check("lat_wait_new", WaitTime, 3);
    for (int i = 0; i < 4; i++) pulse(1'b1, 1'b0);
    check("five_count", People_count, 5);
    check("five_wait", WaitTime, 9);
    check("five_empty", Empty_flag, 0);
    check("five_full", Full_flag, 0);
    check("five_err", Error_flag, 0);

    // Fill to capacity with one teller
    do_reset();
    Tellers_count = 2'd1;
    for (int i = 0; i < 7; i++) pulse(1'b1, 1'b0);
    check("fill_count", People_count, 7);
    check("fill_full", Full_flag, 1);
    check("fill_wait", WaitTime, 21);
    check("fill_err", Error_flag, 0);

    pulse(1'b1, 1'b1);
    check("full_both_count", People_count, 7);
    check("full_both_full", Full_flag, 1);
    check("full_both_err", Error_flag, 0);

    Tellers_count = 2'd3;
    @(negedge clk);
    check("tc3_wait", WaitTime, 9);
    check("tc3_count", People_count, 7);
    Tellers_count = 2'd0;
    @(negedge clk);
    check("tc0_wait", WaitTime, 21);

    pulse(1'b1, 1'b0);
    check("over_count", People_count, 7);
    check("over_full", Full_flag, 1);
    check("over_err", Error_flag, 1);
`ifdef SBQM_REJECT_CNT_EN
    check("over_reject", Reject_count, 1);
`endif

    pulse(1'b0, 1'b1);
    check("exit_full_count", People_count, 6);
    check("exit_full_full", Full_flag, 0);
    check("exit_full_wait", WaitTime, 18);

    // Underflow and simultaneous events on an empty queue
    do_reset();
    pulse(1'b0, 1'b1);
    check("under_count", People_count, 0);
    check("under_empty", Empty_flag, 1);
    check("under_err", Error_flag, 1);
    pulse(1'b1, 1'b1);
    check("empty_both_count", People_count, 1);
    check("empty_both_empty", Empty_flag, 0);
    check("empty_both_wait", WaitTime, 3);
    check("empty_both_err", Error_flag, 1);
    pulse(1'b0, 1'b1);
    check("drain_count", People_count, 0);
    check("drain_empty", Empty_flag, 1);
    check("drain_wait", WaitTime, 0);

    // Long sensor pulse, then reset in the middle of it
    do_reset();
    sensor_start = 1'b1;
    for (int i = 0; i < 10; i++) @(negedge clk);
    check("hold_count", People_count, 1);
    RESET = 1'b0;
    @(negedge clk);
    check("midrst_count", People_count, 0);
    check("midrst_empty", Empty_flag, 1);
    check("midrst_wait", WaitTime, 0);
    check("midrst_err", Error_flag, 0);
    RESET = 1'b1;
    for (int i = 0; i < 4; i++) @(negedge clk);
    check("release_count", People_count, 0);
    check("release_empty", Empty_flag, 1);
    sensor_start = 1'b0;
    @(negedge clk);
    pulse(1'b1, 1'b0);
    check("after_count", People_count, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
